ctrl_noc_req_arbiter: RTL and testbench
=======================================

// Module: ctrl_noc_req_arbiter
// PURPOSE
//  Sits directly downstream of the per-accelerator request FSMs.
//  Round-robin arbitrates their internal requests (key/text reads, execute, write-addr/data) into one
//  registered output slot towards the NoC. Returns arb_won to the winning FSM.
//  Routes NoC acks back to the issuing FSM by source ID.
//  Blocks new grants while the completion serializer is claiming the scoreboard.
// PARAMETERS
//  N_FSM             4  number of requesting FSMs (>=2)
//  ADDR_W            10 address width
//  ADDR_W_ENCODING_W 3  width-encoding field width
//  OPCODE_W          2  opcode width
//  SRC_ID_W          4  source ID width
//  DEST_W            4  destination ID width
//  SRC_ID_BASE       0  FSM i owns source ID SRC_ID_BASE+i; requires SRC_ID_BASE+N_FSM <= 2**SRC_ID_W
// PORTS
//  clk           in  1                     clock
//  rst_n         in  1                     reset; one clock; asynchronous, active-low
//  req_valid     in  N_FSM                 per-FSM request valid (held until arb_won)
//  req_addr      in  N_FSM*ADDR_W          per-FSM address, slice i = FSM i
//  req_width     in  N_FSM*ADDR_W_ENCODING_W  per-FSM width encoding
//  req_dest      in  N_FSM*DEST_W          per-FSM destination
//  req_opcode    in  N_FSM*OPCODE_W        per-FSM opcode
//  req_is_mem    in  N_FSM                 1 = memory request, 0 = accelerator request
//  arb_won       out N_FSM                 one-hot grant pulse, combinational
//  ack           out N_FSM                 per-FSM ack pulse, registered
//  ser_block     in  1                     serializer arbiter has a winner this cycle; suppress grants
//  out_valid     out 1                     NoC request valid
//  out_ready     in  1                     NoC accepts request
//  out_addr      out ADDR_W                granted request fields: addr
//  out_width     out ADDR_W_ENCODING_W     granted request fields: width
//  out_dest      out DEST_W                granted request fields: dest
//  out_opcode    out OPCODE_W              granted request fields: opcode
//  out_source_id out SRC_ID_W              granted request fields: source ID (= SRC_ID_BASE + winner)
//  out_is_mem    out 1                     granted request fields: is_mem
//  ack_valid     in  1                     NoC ack valid
//  ack_source_id in  SRC_ID_W              NoC ack source ID
//  ack_err       out 1                     registered pulse: ack for unknown or non-pending source
// BEHAVIOUR
//  Reset values:
//   - arb_won, ack, ack_err, out_valid = 0.
//   - All out_* fields = 0; pending = 0; rr_ptr = 0.
//  Slot free:
//   - slot_free = !out_valid | out_ready.
//  Eligibility:
//   - elig[i] = req_valid[i] & !pending[i].
//   - Grant only when slot_free & !ser_block & |elig.
//  Priority:
//   - Round-robin, search elig starting at rr_ptr, wrap at N_FSM-1 -> 0.
//   - On grant to w: rr_ptr <= (w==N_FSM-1) ? 0 : w+1. No grant -> rr_ptr holds.
//  Grant cycle:
//   - arb_won[w] = 1 in the same cycle.
//   - At the edge: out_* <= FSM w fields, out_source_id <= SRC_ID_BASE+w, out_valid <= 1, pending[w] <= 1.
//   - Latency: req_valid at cycle t -> arb_won at t -> out_valid at t+1.
//  Output slot:
//   - out_* stable while out_valid & !out_ready.
//   - out_valid & out_ready with no new grant -> out_valid <= 0.
//   - Back-to-back accept: 1 request per cycle.
//  Ack, known source:
//   - ack_valid with id = SRC_ID_BASE+i and pending[i] -> ack[i] pulses at t+1; pending[i] clears at that edge.
//   - FSM i is eligible again from t+1.
//  Ack, bad source:
//   - id out of range, or pending[i]=0 -> no ack, ack_err pulses at t+1.
//  Simultaneous events:
//   - Ack for i and grant for j != i in the same cycle: both take effect.
//   - Grant to i while ack for i is impossible, since pending masks eligibility.
//  ser_block: arb_won = 0 and the slot is not loaded; the current out_valid still drains normally.
//  Reset mid-operation: the in-flight slot is dropped; pending and rr_ptr are cleared; FSMs re-request.
//  Width rules: winner index is $clog2(N_FSM) bits; source ID = SRC_ID_BASE + index, zero-extended to SRC_ID_W.
// STRUCTURE
//  Shared package (ctrl_pkg, alongside common.sv):
//   - Opcode constants (MEM_OPCODE_READ, MEM_OPCODE_WRITE_ADDR, ACCEL_OPCODE_WRITE_DATA).
//   - internal_req_t struct; width parameters.
//  Sub-module rr_arbiter #(N):
//   - Ports: elig, ptr -> one-hot grant, index, any.
//   - Purely combinational; rr_ptr register lives in the parent.
//  Parent holds: output slot register, pending vector, ack decode/register.
// TESTING
//  1. Single request: req_valid[1]=1, out_ready=1, addr 0x2A
//     -> arb_won=0b0010 same cycle; out_valid=1, out_addr=0x2A, out_source_id=1 next cycle.
//  2. Round-robin fairness: all 4 FSMs requesting, pending cleared each cycle by acks
//     -> grant order 0,1,2,3,0.
//  3. Backpressure: out_ready=0 for 5 cycles while FSM2 requests after FSM0 granted
//     -> out_* hold FSM0 values, arb_won=0; FSM2 is granted in the cycle out_ready=1.
//  4. Ack routing and masking: FSM3 granted, held req_valid[3]=1
//     -> no second grant; ack_valid with id 3 -> ack=0b1000 next cycle; regrant the cycle after.
//  5. Bad ack: ack_source_id=9, or id 2 with pending[2]=0
//     -> ack=0, ack_err=1 for one cycle.
//  6. ser_block=1 with FSM0 requesting
//     -> no grant, rr_ptr unchanged; deasserting ser_block grants FSM0.
//  7. Async reset asserted mid-transfer (out_valid=1)
//     -> out_valid, pending, ack = 0 immediately.

Source files
------------

// File: rtl/ctrl_noc_req_arbiter_pkg.sv
// Shared types and constants for the NoC request arbiter slice.
// Default widths, opcode encodings and the FSM-side request bundle.
// Contents:
//   *_DEF        default parameter values used by the arbiter top
//   *_OPCODE_*   opcode encodings driven by the request FSMs
//   internal_req_t  one FSM request at default widths
//   next_ptr()   round-robin pointer advance with wrap
package ctrl_noc_req_arbiter_pkg;

  localparam int N_FSM_DEF             = 4;
  localparam int ADDR_W_DEF            = 10;
  localparam int ADDR_W_ENCODING_W_DEF = 3;
  localparam int OPCODE_W_DEF          = 2;
  localparam int SRC_ID_W_DEF          = 4;
  localparam int DEST_W_DEF            = 4;
  localparam int SRC_ID_BASE_DEF       = 0;

  localparam logic [OPCODE_W_DEF-1:0] MEM_OPCODE_READ         = 2'd0;
  localparam logic [OPCODE_W_DEF-1:0] MEM_OPCODE_WRITE_ADDR   = 2'd1;
  localparam logic [OPCODE_W_DEF-1:0] ACCEL_OPCODE_WRITE_DATA = 2'd2;

  typedef struct packed {
    logic [ADDR_W_DEF-1:0]            addr;
    logic [ADDR_W_ENCODING_W_DEF-1:0] width;
    logic [DEST_W_DEF-1:0]            dest;
    logic [OPCODE_W_DEF-1:0]          opcode;
    logic                             is_mem;
  } internal_req_t;

  // Pointer moves one past the winner so the winner has lowest priority next.
  function automatic int next_ptr(input int idx, input int n);
    return (idx == n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/ctrl_noc_req_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first eligible requester at or after ptr, wrapping.
// Latency: zero (pure combinational); pointer register lives in the parent.
// Backpressure: none here; parent gates the result with slot/serializer state.
// Ports:
//   elig  in  N          eligible requesters
//   ptr   in  clog2(N)   highest-priority index this cycle
//   grant out N          one-hot winner (0 when none eligible)
//   idx   out clog2(N)   winner index
//   any   out 1          at least one requester eligible
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         elig,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] idx,
  output logic                 any
);

  localparam int IDX_W = $clog2(N);

  logic             hi_hit;
  logic [IDX_W-1:0] hi_idx;
  logic             lo_hit;
  logic [IDX_W-1:0] lo_idx;

  // Two searches: lowest eligible index >= ptr, else lowest eligible overall
  // (the wrap-around case). Descending loop leaves the lowest index last.
  always_comb begin
    hi_hit = 1'b0;
    hi_idx = '0;
    lo_hit = 1'b0;
    lo_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (elig[i] && (IDX_W'(i) >= ptr)) begin
        hi_hit = 1'b1;
        hi_idx = IDX_W'(i);
      end
      if (elig[i]) begin
        lo_hit = 1'b1;
        lo_idx = IDX_W'(i);
      end
    end
    idx   = hi_hit ? hi_idx : lo_idx;
    any   = lo_hit;
    grant = '0;
    if (lo_hit) grant[idx] = 1'b1;
  end

endmodule

// File: rtl/ctrl_noc_req_arbiter.sv
// Round-robin arbiter of per-FSM requests into one registered NoC slot; routes acks back by source ID.
// Latency: req_valid at t -> arb_won at t (comb) -> out_valid at t+1; ack_valid at t -> ack/ack_err at t+1.
// Backpressure: out_ready low holds the slot and blocks grants; ser_block suppresses grants only.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   req_valid/addr/width/dest/opcode/is_mem  per-FSM request, slice i = FSM i
//   arb_won                         one-hot grant pulse (comb)
//   ack, ack_err                    registered per-FSM ack pulse / bad-ack pulse
//   ser_block                       serializer owns the scoreboard this cycle
//   out_valid/ready, out_*          NoC request slot
//   ack_valid, ack_source_id        NoC ack input
module ctrl_noc_req_arbiter
  import ctrl_noc_req_arbiter_pkg::*;
#(
  parameter int N_FSM             = N_FSM_DEF,
  parameter int ADDR_W            = ADDR_W_DEF,
  parameter int ADDR_W_ENCODING_W = ADDR_W_ENCODING_W_DEF,
  parameter int OPCODE_W          = OPCODE_W_DEF,
  parameter int SRC_ID_W          = SRC_ID_W_DEF,
  parameter int DEST_W            = DEST_W_DEF,
  parameter int SRC_ID_BASE       = SRC_ID_BASE_DEF
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [N_FSM-1:0]                     req_valid,
  input  logic [N_FSM*ADDR_W-1:0]              req_addr,
  input  logic [N_FSM*ADDR_W_ENCODING_W-1:0]   req_width,
  input  logic [N_FSM*DEST_W-1:0]              req_dest,
  input  logic [N_FSM*OPCODE_W-1:0]            req_opcode,
  input  logic [N_FSM-1:0]                     req_is_mem,
  output logic [N_FSM-1:0]                     arb_won,
  output logic [N_FSM-1:0]                     ack,
  input  logic                                 ser_block,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [ADDR_W-1:0]                    out_addr,
  output logic [ADDR_W_ENCODING_W-1:0]         out_width,
  output logic [DEST_W-1:0]                    out_dest,
  output logic [OPCODE_W-1:0]                  out_opcode,
  output logic [SRC_ID_W-1:0]                  out_source_id,
  output logic                                 out_is_mem,
  input  logic                                 ack_valid,
  input  logic [SRC_ID_W-1:0]                  ack_source_id,
  output logic                                 ack_err
);

  localparam int IDX_W = $clog2(N_FSM);

  typedef struct packed {
    logic [ADDR_W-1:0]            addr;
    logic [ADDR_W_ENCODING_W-1:0] width;
    logic [DEST_W-1:0]            dest;
    logic [OPCODE_W-1:0]          opcode;
    logic [SRC_ID_W-1:0]          source_id;
    logic                         is_mem;
  } slot_t;

  slot_t            slot_q, slot_d, sel_req;
  logic             out_valid_q, out_valid_d;
  logic [N_FSM-1:0] pending_q, pending_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [N_FSM-1:0] ack_q, ack_d;
  logic             ack_err_q, ack_err_d;

  logic [N_FSM-1:0] elig;
  logic [N_FSM-1:0] rr_grant;
  logic [IDX_W-1:0] rr_idx;
  logic             rr_any;
  logic             slot_free;
  logic             do_grant;
  logic [N_FSM-1:0] ack_hit;
  logic [N_FSM-1:0] ack_match;

  // An FSM with a request in flight is masked until its ack returns.
  assign elig = req_valid & ~pending_q;

  rr_arbiter #(.N(N_FSM)) u_rr_arbiter (
    .elig  (elig),
    .ptr   (rr_ptr_q),
    .grant (rr_grant),
    .idx   (rr_idx),
    .any   (rr_any)
  );

  always_comb begin
    slot_free = !out_valid_q || out_ready;
    do_grant  = slot_free && !ser_block && rr_any;
    arb_won   = do_grant ? rr_grant : '0;
  end

  // Field mux for the current winner.
  always_comb begin
    sel_req = '0;
    for (int i = 0; i < N_FSM; i++) begin
      if (rr_grant[i]) begin
        sel_req.addr   = req_addr[i*ADDR_W +: ADDR_W];
        sel_req.width  = req_width[i*ADDR_W_ENCODING_W +: ADDR_W_ENCODING_W];
        sel_req.dest   = req_dest[i*DEST_W +: DEST_W];
        sel_req.opcode = req_opcode[i*OPCODE_W +: OPCODE_W];
        sel_req.is_mem = req_is_mem[i];
      end
    end
    sel_req.source_id = SRC_ID_W'(SRC_ID_BASE) + SRC_ID_W'(rr_idx);
  end

  // Ack decode: an ID outside the owned range hits nothing, so it and an
  // ack for a non-pending FSM both land on ack_err.
  always_comb begin
    ack_hit = '0;
    for (int i = 0; i < N_FSM; i++) begin
      ack_hit[i] = (ack_source_id == SRC_ID_W'(SRC_ID_BASE + i));
    end
    ack_match = ack_hit & pending_q;
    ack_d     = ack_valid ? ack_match : '0;
    ack_err_d = ack_valid && !(|ack_match);
  end

  // A grant and an ack never target the same FSM (pending masks eligibility),
  // so set and clear can be applied independently.
  always_comb begin
    pending_d   = (pending_q & ~ack_d) | arb_won;
    slot_d      = slot_q;
    out_valid_d = out_valid_q;
    rr_ptr_d    = rr_ptr_q;
    if (do_grant) begin
      slot_d      = sel_req;
      out_valid_d = 1'b1;
      rr_ptr_d    = IDX_W'(next_ptr(int'(rr_idx), N_FSM));
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q      <= '0;
      out_valid_q <= 1'b0;
      pending_q   <= '0;
      rr_ptr_q    <= '0;
      ack_q       <= '0;
      ack_err_q   <= 1'b0;
    end else begin
      slot_q      <= slot_d;
      out_valid_q <= out_valid_d;
      pending_q   <= pending_d;
      rr_ptr_q    <= rr_ptr_d;
      ack_q       <= ack_d;
      ack_err_q   <= ack_err_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign out_addr      = slot_q.addr;
  assign out_width     = slot_q.width;
  assign out_dest      = slot_q.dest;
  assign out_opcode    = slot_q.opcode;
  assign out_source_id = slot_q.source_id;
  assign out_is_mem    = slot_q.is_mem;
  assign ack           = ack_q;
  assign ack_err       = ack_err_q;

endmodule

// File: tb/tb_ctrl_noc_req_arbiter.sv
// Self-checking bench for ctrl_noc_req_arbiter: directed scenarios then random traffic.
// Latency: checks comb grant at negedge, registered outputs 1 time unit after posedge.
// Backpressure: out_ready/ser_block driven directly and randomly.
module tb_ctrl_noc_req_arbiter;

  localparam int N    = 4;
  localparam int AW   = 10;
  localparam int WW   = 3;
  localparam int OW   = 2;
  localparam int SW   = 4;
  localparam int DW   = 4;
  localparam int BASE = 0;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [N-1:0]      req_valid = '0;
  logic [N*AW-1:0]   req_addr = '0;
  logic [N*WW-1:0]   req_width = '0;
  logic [N*DW-1:0]   req_dest = '0;
  logic [N*OW-1:0]   req_opcode = '0;
  logic [N-1:0]      req_is_mem = '0;
  logic [N-1:0]      arb_won;
  logic [N-1:0]      ack;
  logic              ser_block = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [AW-1:0]     out_addr;
  logic [WW-1:0]     out_width;
  logic [DW-1:0]     out_dest;
  logic [OW-1:0]     out_opcode;
  logic [SW-1:0]     out_source_id;
  logic              out_is_mem;
  logic              ack_valid = 1'b0;
  logic [SW-1:0]     ack_source_id = '0;
  logic              ack_err;

  ctrl_noc_req_arbiter #(
    .N_FSM(N), .ADDR_W(AW), .ADDR_W_ENCODING_W(WW), .OPCODE_W(OW),
    .SRC_ID_W(SW), .DEST_W(DW), .SRC_ID_BASE(BASE)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_addr(req_addr), .req_width(req_width),
    .req_dest(req_dest), .req_opcode(req_opcode), .req_is_mem(req_is_mem),
    .arb_won(arb_won), .ack(ack), .ser_block(ser_block),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
    .out_width(out_width), .out_dest(out_dest), .out_opcode(out_opcode),
    .out_source_id(out_source_id), .out_is_mem(out_is_mem),
    .ack_valid(ack_valid), .ack_source_id(ack_source_id), .ack_err(ack_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: which FSMs have something in flight, who is next in line,
  // and what the NoC slot holds.
  bit            m_pend [N];
  int            m_ptr;
  bit            m_ov;
  logic [AW-1:0] m_addr;
  logic [WW-1:0] m_width;
  logic [DW-1:0] m_dest;
  logic [OW-1:0] m_op;
  logic [SW-1:0] m_src;
  bit            m_mem;
  logic [N-1:0]  m_ack;
  bit            m_err;
  logic [N-1:0]  exp_won;
  int            win;
  logic [N-1:0]  last_won;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_pend[i] = 1'b0;
    m_ptr = 0; m_ov = 1'b0; m_ack = '0; m_err = 1'b0; exp_won = '0; win = -1;
    m_addr = '0; m_width = '0; m_dest = '0; m_op = '0; m_src = '0; m_mem = 1'b0;
  endtask

  // Who should win this cycle: first requesting, non-pending FSM counting
  // from the pointer, provided the slot can take it and nothing blocks.
  task automatic model_comb();
    bit free;
    win = -1;
    exp_won = '0;
    free = !m_ov || out_ready;
    if (free && !ser_block) begin
      for (int k = 0; k < N; k++) begin
        int c;
        c = (m_ptr + k) % N;
        if (win < 0 && req_valid[c] && !m_pend[c]) win = c;
      end
    end
    if (win >= 0) exp_won[win] = 1'b1;
  endtask

  task automatic model_edge();
    m_ack = '0;
    m_err = 1'b0;
    if (ack_valid) begin
      int id;
      id = int'(ack_source_id);
      if (id >= BASE && id < BASE + N && m_pend[id - BASE]) begin
        m_ack[id - BASE] = 1'b1;
        m_pend[id - BASE] = 1'b0;
      end else begin
        m_err = 1'b1;
      end
    end
    if (win >= 0) begin
      m_pend[win] = 1'b1;
      m_ov    = 1'b1;
      m_addr  = req_addr[win*AW +: AW];
      m_width = req_width[win*WW +: WW];
      m_dest  = req_dest[win*DW +: DW];
      m_op    = req_opcode[win*OW +: OW];
      m_src   = SW'(BASE + win);
      m_mem   = req_is_mem[win];
      m_ptr   = (win + 1) % N;
    end else if (out_ready) begin
      m_ov = 1'b0;
    end
  endtask

  task automatic check_regs();
    chk("out_valid", out_valid, m_ov);
    if (m_ov)
      chk("out_fields",
          {out_addr, out_width, out_dest, out_opcode, out_source_id, out_is_mem},
          {m_addr, m_width, m_dest, m_op, m_src, m_mem});
    chk("ack", ack, m_ack);
    chk("ack_err", ack_err, m_err);
  endtask

  // One clock: comb grant checked at negedge, registered state after posedge.
  task automatic cycle();
    @(negedge clk);
    model_comb();
    last_won = arb_won;
    chk("arb_won", arb_won, exp_won);
    @(posedge clk);
    model_edge();
    #1;
    check_regs();
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [WW-1:0] w,
                         input logic [DW-1:0] d, input logic [OW-1:0] o, input logic m);
    req_valid[i] = 1'b1;
    req_addr[i*AW +: AW] = a;
    req_width[i*WW +: WW] = w;
    req_dest[i*DW +: DW] = d;
    req_opcode[i*OW +: OW] = o;
    req_is_mem[i] = m;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = '0; ser_block = 1'b0; out_ready = 1'b0; ack_valid = 1'b0; ack_source_id = '0;
    #1;
    model_reset();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_fields", {out_addr, out_width, out_dest, out_opcode, out_source_id, out_is_mem}, 0);
    chk("rst_ack", ack, 0);
    chk("rst_ack_err", ack_err, 0);
    chk("rst_arb_won", arb_won, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  logic [N-1:0] rr_exp [5];

  initial begin
    rr_exp[0] = 4'b0001; rr_exp[1] = 4'b0010; rr_exp[2] = 4'b0100;
    rr_exp[3] = 4'b1000; rr_exp[4] = 4'b0001;
    model_reset();
    @(posedge clk);
    do_reset();

    // Single request from FSM1.
    out_ready = 1'b1;
    set_req(1, 10'h2A, 3'd2, 4'd5, 2'd1, 1'b1);
    cycle();
    chk("t1_won", last_won, 4'b0010);
    chk("t1_addr", out_addr, 10'h2A);
    chk("t1_src", out_source_id, 1);
    req_valid[1] = 1'b0;
    ack_valid = 1'b1; ack_source_id = 4'd1;
    cycle();
    chk("t1_ack", ack, 4'b0010);
    ack_valid = 1'b0;
    cycle();

    // Round-robin fairness, acking the previous winner each cycle.
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < N; i++)
      set_req(i, AW'(16 * i + 3), WW'(i), DW'(i + 8), OW'(i), i[0]);
    for (int k = 0; k < 5; k++) begin
      cycle();
      chk("t2_order", last_won, rr_exp[k]);
      ack_valid = 1'b1;
      ack_source_id = SW'(BASE + (k % N));
    end
    ack_valid = 1'b0;
    req_valid = '0;
    cycle();

    // Backpressure: FSM0 in the slot, FSM2 waits until out_ready returns.
    do_reset();
    out_ready = 1'b1;
    set_req(0, 10'h155, 3'd1, 4'd3, 2'd0, 1'b1);
    cycle();
    req_valid[0] = 1'b0;
    out_ready = 1'b0;
    set_req(2, 10'h0F0, 3'd4, 4'd9, 2'd2, 1'b0);
    for (int k = 0; k < 5; k++) begin
      cycle();
      chk("t3_hold_won", last_won, 0);
      chk("t3_hold_addr", out_addr, 10'h155);
    end
    out_ready = 1'b1;
    cycle();
    chk("t3_won", last_won, 4'b0100);
    chk("t3_addr", out_addr, 10'h0F0);
    req_valid[2] = 1'b0;
    cycle();

    // Pending masks a held request until the ack returns.
    do_reset();
    out_ready = 1'b1;
    set_req(3, 10'h3C3, 3'd7, 4'd1, 2'd1, 1'b1);
    cycle();
    chk("t4_won", last_won, 4'b1000);
    cycle();
    chk("t4_masked", last_won, 0);
    ack_valid = 1'b1; ack_source_id = 4'd3;
    cycle();
    chk("t4_ack", ack, 4'b1000);
    ack_valid = 1'b0;
    cycle();
    chk("t4_regrant", last_won, 4'b1000);

    // Bad acks: out-of-range ID, then an ID whose FSM has nothing pending.
    ack_valid = 1'b1; ack_source_id = 4'd9;
    cycle();
    chk("t5_err_range", ack_err, 1);
    ack_source_id = 4'd2;
    cycle();
    chk("t5_err_idle", ack_err, 1);
    chk("t5_no_ack", ack, 0);
    ack_valid = 1'b0;
    cycle();
    chk("t5_err_clear", ack_err, 0);

    // ser_block suppresses grants without moving the pointer.
    req_valid[3] = 1'b0;
    set_req(0, 10'h011, 3'd3, 4'd2, 2'd0, 1'b0);
    ser_block = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("t6_blocked", last_won, 0);
    end
    ser_block = 1'b0;
    out_ready = 1'b0;
    cycle();
    chk("t6_won", last_won, 4'b0001);

    // Async reset with a request sitting in the slot.
    chk("t7_pre_valid", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t7_valid", out_valid, 0);
    chk("t7_ack", ack, 0);
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    cycle();
    chk("t7_regrant", last_won, 4'b0001);

    // Random traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      out_ready = ($urandom % 4) != 0;
      ser_block = ($urandom % 5) == 0;
      ack_valid = ($urandom % 2) == 1;
      ack_source_id = ($urandom % 5 == 0) ? SW'($urandom_range(0, 15))
                                           : SW'(BASE + $urandom_range(0, N - 1));
      for (int i = 0; i < N; i++) begin
        if (exp_won[i]) req_valid[i] = ($urandom % 2) == 1;
        else if (!req_valid[i] && ($urandom % 3) == 0)
          set_req(i, AW'($urandom), WW'($urandom), DW'($urandom), OW'($urandom), $urandom % 2 == 1);
      end
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
